// File: rtl/serial_port_controller_pkg.sv
// Shared types and constants for the serial port controller.
// The optional START glitch check is enabled by SERIAL_PORT_CONTROLLER_GLITCH_FILTER_EN.
package serial_port_controller_pkg;

  localparam int PORT_W = 2;
  localparam int DATA_W = 8;
  localparam int NPORTS = 4;
  localparam int CNT_W  = 3;

  // One-hot encodings; bit index matches the debug vector fl.
  typedef enum logic [8:0] {
    IDLE   = 9'b000000001,
    START  = 9'b000000010,
    ADDR_H = 9'b000000100,
    ADDR_L = 9'b000001000,
    DATA   = 9'b000010000,
    STOP   = 9'b000100000,
    VALID  = 9'b001000000,
    ERROR  = 9'b010000000,
    WAIT   = 9'b100000000
  } state_t;

  function automatic logic [NPORTS-1:0] port_onehot(input logic [PORT_W-1:0] port);
    port_onehot = NPORTS'(1) << port;
  endfunction

endpackage

// File: rtl/serial_port_controller_counter_3b.sv
// 3-bit payload bit counter with synchronous clear, enable and carry-out at count==7.
module counter_3b
  import serial_port_controller_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic co
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign co = (cnt_reg == {CNT_W{1'b1}});

endmodule

// File: rtl/serial_port_controller.sv
// Serial frame receiver: start bit(s), 2-bit port, 8-bit payload MSB-first, stop bit.
// Define SERIAL_PORT_CONTROLLER_GLITCH_FILTER_EN to require a second start 1 in START.
module serial_port_controller
  import serial_port_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  output logic [NPORTS-1:0] p,
  output logic              outvalid,
  output logic              error,
  output logic [8:0]        fl,
  output logic [PORT_W-1:0] cur,
  output logic [DATA_W-1:0] shift_out,
  output logic              CO3BFLAG
);

  state_t              state_reg, state_next;
  logic [PORT_W-1:0]   cur_reg;
  logic [DATA_W-1:0]   shift_reg;
  logic                cnt_clr, cnt_en, cnt_co;

  counter_3b u_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .co  (cnt_co)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Address and payload capture; values persist until the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_reg   <= '0;
      shift_reg <= '0;
    end else begin
      if (state_reg == ADDR_H) cur_reg[1] <= sin;
      if (state_reg == ADDR_L) cur_reg[0] <= sin;
      if (state_reg == DATA)   shift_reg  <= {shift_reg[DATA_W-2:0], sin};
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    outvalid   = 1'b0;
    error      = 1'b0;
    p          = '0;
    case (state_reg)
      IDLE:   if (sin) state_next = START;
`ifdef SERIAL_PORT_CONTROLLER_GLITCH_FILTER_EN
      START:  state_next = sin ? ADDR_H : IDLE;
`else
      START:  state_next = ADDR_H;
`endif
      ADDR_H: state_next = ADDR_L;
      ADDR_L: begin
        cnt_clr    = 1'b1;
        state_next = DATA;
      end
      DATA: begin
        cnt_en = 1'b1;
        if (cnt_co) state_next = STOP;
      end
      STOP:   state_next = sin ? ERROR : VALID;
      VALID: begin
        outvalid   = 1'b1;
        p          = port_onehot(cur_reg);
        state_next = WAIT;
      end
      ERROR: begin
        error      = 1'b1;
        state_next = WAIT;
      end
      WAIT:   if (!sin) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign fl        = state_reg;
  assign cur       = cur_reg;
  assign shift_out = shift_reg;
  assign CO3BFLAG  = cnt_co;

endmodule

// File: tb/tb_serial_port_controller.sv
// Directed scoreboard bench for serial_port_controller; honours SERIAL_PORT_CONTROLLER_GLITCH_FILTER_EN.
module tb_serial_port_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic [3:0] p;
  logic       outvalid, error;
  logic [8:0] fl;
  logic [1:0] cur;
  logic [7:0] shift_out;
  logic       CO3BFLAG;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       err;
    logic [1:0] port;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  serial_port_controller dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .p         (p),
    .outvalid  (outvalid),
    .error     (error),
    .fl        (fl),
    .cur       (cur),
    .shift_out (shift_out),
    .CO3BFLAG  (CO3BFLAG)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_outvalid"}, 16'(outvalid), 16'd0);
    check({tag, "_error"},    16'(error),    16'd0);
    check({tag, "_p"},        16'(p),        16'd0);
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  // Two start 1s are valid in both builds; the second is ignored without the filter.
  task automatic send_frame(input logic [1:0] port, input logic [7:0] data, input logic stop);
    exp_t e;
    e.err = stop; e.port = port; e.data = data;
    sb.push_back(e);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("start_state", 16'(fl), 16'h002);
    drive_bit(port[1]);
    drive_bit(port[0]);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      check("data_state", 16'(fl), 16'h010);
      check("co3bflag", 16'(CO3BFLAG), 16'(i == 0));
      sin = data[i];
    end
    drive_bit(stop);
  endtask

  task automatic wait_strobe();
    exp_t e;
    bit   seen = 0;
    for (int n = 0; n < 6 && !seen; n++) begin
      @(negedge clk);
      if (outvalid || error) seen = 1;
    end
    if (sb.size() == 0) begin
      check("sb_underflow", 16'd1, 16'd0);
      return;
    end
    e = sb.pop_front();
    if (!seen) begin
      check("strobe_timeout", 16'd0, 16'd1);
      return;
    end
    check("outvalid",  16'(outvalid),  16'(!e.err));
    check("error",     16'(error),     16'(e.err));
    check("p",         16'(p),         e.err ? 16'd0 : 16'(4'b0001 << e.port));
    check("cur",       16'(cur),       16'(e.port));
    check("shift_out", 16'(shift_out), 16'(e.data));
    $display("frame port=%0d data=%h err=%0b: outvalid=%0b error=%0b p=%b", e.port, e.data, e.err,
             outvalid, error, p);
    @(negedge clk);
    check_quiet("strobe_end");
    check("wait_state", 16'(fl), 16'h100);
  endtask

  initial begin
    rst = 1'b0;
    sin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_fl", 16'(fl), 16'h001);
    check("rst_cur", 16'(cur), 16'd0);
    check("rst_shift", 16'(shift_out), 16'd0);
    check("rst_co", 16'(CO3BFLAG), 16'd0);
    check_quiet("rst");
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_fl", 16'(fl), 16'h001);
      check_quiet("idle");
    end

    send_frame(2'b10, 8'hA5, 1'b0);
    wait_strobe();

    // Error frame with the line parked high afterwards.
    send_frame(2'b10, 8'hA5, 1'b1);
    wait_strobe();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("park_fl", 16'(fl), 16'h100);
      check_quiet("park");
    end
    sin = 1'b0;
    @(negedge clk);
    check("unpark_fl", 16'(fl), 16'h001);

    // Single-cycle start pulse.
    sin = 1'b1;
    @(negedge clk);
    check("pulse_start", 16'(fl), 16'h002);
    sin = 1'b0;
    @(negedge clk);
`ifdef SERIAL_PORT_CONTROLLER_GLITCH_FILTER_EN
    check("pulse_idle", 16'(fl), 16'h001);
    check("pulse_cur", 16'(cur), 16'd2);
    check_quiet("pulse");
`else
    check("pulse_addr", 16'(fl), 16'h004);
    check_quiet("pulse");
`endif

    // Abort a frame mid-payload with asynchronous reset.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    sin = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    @(negedge clk);
    check("pre_abort_fl", 16'(fl), 16'h010);
    #2;
    rst = 1'b0;
    #1;
    check("abort_fl", 16'(fl), 16'h001);
    check("abort_cur", 16'(cur), 16'd0);
    check("abort_shift", 16'(shift_out), 16'd0);
    check("abort_co", 16'(CO3BFLAG), 16'd0);
    check_quiet("abort");
    @(negedge clk);
    sin = 1'b0;
    rst = 1'b1;

    send_frame(2'b11, 8'hFF, 1'b0);
    wait_strobe();

    // Back-to-back frames with a single idle 0 in WAIT.
    send_frame(2'b01, 8'h3C, 1'b0);
    wait_strobe();
    send_frame(2'b00, 8'hC3, 1'b0);
    wait_strobe();

    check("sb_empty", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
